// File: rtl/bldc_commutation_scheduler_if.sv
// Hall/throttle inputs and gate/debug outputs of the BLDC commutation scheduler.
// The master side drives the run request, hall code and duty; the slave side is the scheduler.
interface bldc_commutation_scheduler_if #(
  parameter int PWM_BITS = 10
);
  logic                enable;
  logic                dir;
  logic [2:0]          HS_in;
  logic [PWM_BITS-1:0] accel;
  logic [5:0]          gate;
  logic [2:0]          HS;
  logic [9:0]          HSCounter;
  logic [15:0]         counter_per_cycle;
  logic [15:0]         delayAngleCounter;
  logic [2:0]          step;
  logic                stall;
  logic                fault;

  modport master (
    output enable, dir, HS_in, accel,
    input  gate, HS, HSCounter, counter_per_cycle, delayAngleCounter, step, stall, fault
  );

  modport slave (
    input  enable, dir, HS_in, accel,
    output gate, HS, HSCounter, counter_per_cycle, delayAngleCounter, step, stall, fault
  );
endinterface

// File: rtl/bldc_commutation_scheduler.sv
// Six-step BLDC commutation: filtered hall decode, sector period timing, period-proportional
// commutation delay and PWM gating of the high-side switches.
module bldc_commutation_scheduler #(
  parameter int PRESCALE    = 50,
  parameter int DELAY_SHIFT = 2,
  parameter int FILTER_LEN  = 8,
  parameter int PWM_BITS    = 10
) (
  input logic                         controlCLK,
  input logic                         rst,
  bldc_commutation_scheduler_if.slave bus
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {IDLE, START, RUN, DELAY, STALL} state_t;
  state_t state_reg, state_next;

  logic [2:0]          hs_s1_reg, hs_s2_reg, cand_reg, hs_reg;
  logic [7:0]          stable_reg;
  logic [PRE_W-1:0]    pre_reg;
  logic [15:0]         period_reg, period_inc, per_latch_reg;
  logic [15:0]         delay_cnt_reg, delay_target_reg;
  logic [9:0]          edge_count_reg;
  logic [2:0]          step_reg, pending_reg, hall_step, target_step;
  logic                fault_reg, pwm_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                tick, edge_any, hall_valid, valid_edge, invalid_edge;
  logic                apply_target, apply_pending, load_delay, enter_stall, delay_run;
  logic [5:0]          gate_drive;

  // A code is accepted once the synchronised value has matched the candidate for FILTER_LEN cycles.
  assign edge_any     = (stable_reg >= 8'(FILTER_LEN)) && (cand_reg != hs_reg);
  assign valid_edge   = edge_any && hall_valid;
  assign invalid_edge = edge_any && !hall_valid;

  always_ff @(posedge controlCLK or posedge rst) begin
    if (rst) begin
      hs_s1_reg  <= 3'd0;
      hs_s2_reg  <= 3'd0;
      cand_reg   <= 3'd0;
      stable_reg <= 8'd0;
      hs_reg     <= 3'd0;
    end else begin
      hs_s1_reg <= bus.HS_in;
      hs_s2_reg <= hs_s1_reg;
      if (hs_s2_reg != cand_reg) begin
        cand_reg   <= hs_s2_reg;
        stable_reg <= 8'd1;
      end else if (stable_reg != 8'hFF) begin
        stable_reg <= stable_reg + 8'd1;
      end
      if (edge_any) hs_reg <= cand_reg;
    end
  end

  always_comb begin
    hall_step  = 3'd0;
    hall_valid = 1'b1;
    case (cand_reg)
      3'd5:    hall_step = 3'd0;
      3'd1:    hall_step = 3'd1;
      3'd3:    hall_step = 3'd2;
      3'd2:    hall_step = 3'd3;
      3'd6:    hall_step = 3'd4;
      3'd4:    hall_step = 3'd5;
      default: hall_valid = 1'b0;
    endcase
  end

  // Forward leads the hall sector by one step; reverse by four (i.e. two behind).
  always_comb begin
    if (bus.dir)
      target_step = (hall_step >= 3'd2) ? hall_step - 3'd2 : hall_step + 3'd4;
    else
      target_step = (hall_step == 3'd5) ? 3'd0 : hall_step + 3'd1;
  end

  assign tick       = (pre_reg == PRE_W'(PRESCALE - 1));
  assign period_inc = (tick && period_reg != 16'hFFFF) ? period_reg + 16'd1 : period_reg;

  always_ff @(posedge controlCLK or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    apply_target  = 1'b0;
    apply_pending = 1'b0;
    load_delay    = 1'b0;
    enter_stall   = 1'b0;
    delay_run     = 1'b0;
    if (!bus.enable || invalid_edge) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  if (!fault_reg) state_next = START;
        START: if (valid_edge) begin
          apply_target = 1'b1;
          state_next   = RUN;
        end
        RUN: begin
          if (valid_edge) begin
            load_delay = 1'b1;
            state_next = DELAY;
          end else if (period_reg == 16'hFFFF) begin
            enter_stall = 1'b1;
            state_next  = STALL;
          end
        end
        DELAY: begin
          // A fresh edge flushes the outstanding step before the new delay starts.
          if (valid_edge) begin
            apply_pending = 1'b1;
            load_delay    = 1'b1;
          end else if (delay_cnt_reg >= delay_target_reg) begin
            apply_pending = 1'b1;
            state_next    = RUN;
          end else if (period_reg == 16'hFFFF) begin
            enter_stall = 1'b1;
            state_next  = STALL;
          end else begin
            delay_run = 1'b1;
          end
        end
        STALL: if (valid_edge) begin
          apply_target = 1'b1;
          state_next   = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge controlCLK or posedge rst) begin
    if (rst) begin
      pre_reg          <= '0;
      period_reg       <= 16'd0;
      per_latch_reg    <= 16'd0;
      delay_cnt_reg    <= 16'd0;
      delay_target_reg <= 16'd0;
      pending_reg      <= 3'd0;
      step_reg         <= 3'd0;
      edge_count_reg   <= 10'd0;
      fault_reg        <= 1'b0;
      pwm_cnt_reg      <= '0;
      pwm_reg          <= 1'b0;
    end else begin
      pre_reg     <= tick ? '0 : pre_reg + PRE_W'(1);
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
      pwm_reg     <= (pwm_cnt_reg < bus.accel);
      period_reg  <= valid_edge ? 16'd0 : period_inc;

      // The tick coinciding with the edge belongs to the sector that is closing.
      if (valid_edge)       per_latch_reg <= period_inc;
      else if (enter_stall) per_latch_reg <= 16'hFFFF;

      if (load_delay) begin
        delay_target_reg <= period_inc >> DELAY_SHIFT;
        delay_cnt_reg    <= 16'd0;
        pending_reg      <= target_step;
      end else if (delay_run && tick) begin
        delay_cnt_reg <= delay_cnt_reg + 16'd1;
      end

      if (apply_target)       step_reg <= target_step;
      else if (apply_pending) step_reg <= pending_reg;

      if (valid_edge && state_reg != IDLE) edge_count_reg <= edge_count_reg + 10'd1;

      if (!bus.enable)       fault_reg <= 1'b0;
      else if (invalid_edge) fault_reg <= 1'b1;
    end
  end

  // Gate order {AH,AL,BH,BL,CH,CL}; only the high side is chopped.
  always_comb begin
    gate_drive = 6'b000000;
    if (state_reg == RUN || state_reg == DELAY) begin
      case (step_reg)
        3'd0:    gate_drive = {pwm_reg, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        3'd1:    gate_drive = {pwm_reg, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        3'd2:    gate_drive = {1'b0, 1'b0, pwm_reg, 1'b0, 1'b0, 1'b1};
        3'd3:    gate_drive = {1'b0, 1'b1, pwm_reg, 1'b0, 1'b0, 1'b0};
        3'd4:    gate_drive = {1'b0, 1'b1, 1'b0, 1'b0, pwm_reg, 1'b0};
        3'd5:    gate_drive = {1'b0, 1'b0, 1'b0, 1'b1, pwm_reg, 1'b0};
        default: gate_drive = 6'b000000;
      endcase
    end
  end

  assign bus.gate              = gate_drive;
  assign bus.HS                = hs_reg;
  assign bus.HSCounter         = edge_count_reg;
  assign bus.counter_per_cycle = per_latch_reg;
  assign bus.delayAngleCounter = delay_cnt_reg;
  assign bus.step              = step_reg;
  assign bus.stall             = (state_reg == STALL);
  assign bus.fault             = fault_reg;
endmodule

// File: tb/tb_bldc_commutation_scheduler.sv
// Directed bench for the commutation scheduler: one instance at the default timebase and a
// second with a one-cycle tick so that period saturation is reachable in a short run.
module tb_bldc_commutation_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_s;
  bit   stall_done = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bldc_commutation_scheduler_if bus ();
  bldc_commutation_scheduler_if bus_s ();

  bldc_commutation_scheduler u_dut (
    .controlCLK(clk),
    .rst       (rst),
    .bus       (bus)
  );

  bldc_commutation_scheduler #(.PRESCALE(1)) u_stall (
    .controlCLK(clk),
    .rst       (rst_s),
    .bus       (bus_s)
  );

  typedef struct {
    logic [2:0] hs;
    logic [2:0] exp_step;
    logic [5:0] exp_mask;
    logic [5:0] low_bit;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Main sequence on the default-timebase instance.
  initial begin
    vec_t vecs[6];
    int   acc_tab[3];
    int   ch_exp[3];
    int   t_chg, ch_cnt, bl_cnt, bad_cnt;
    logic [2:0] prev;

    vecs[0] = '{3'd1, 3'd2, 6'h09, 6'h01};
    vecs[1] = '{3'd3, 3'd3, 6'h18, 6'h10};
    vecs[2] = '{3'd2, 3'd4, 6'h12, 6'h10};
    vecs[3] = '{3'd6, 3'd5, 6'h06, 6'h04};
    vecs[4] = '{3'd4, 3'd0, 6'h24, 6'h04};
    vecs[5] = '{3'd5, 3'd1, 6'h21, 6'h01};
    acc_tab = '{256, 0, 1023};
    ch_exp  = '{256, 0, 1023};

    rst = 1'b1;
    bus.enable = 1'b1;
    bus.dir    = 1'b0;
    bus.HS_in  = 3'd5;
    bus.accel  = 10'd1023;
    cyc(3);
    check("rst_gate", 32'(bus.gate), 0);
    check("rst_step", 32'(bus.step), 0);
    check("rst_hscnt", 32'(bus.HSCounter), 0);
    check("rst_per", 32'(bus.counter_per_cycle), 0);
    check("rst_hs", 32'(bus.HS), 0);
    check("rst_fault", 32'(bus.fault), 0);

    // Startup: filter latency 2+8 then immediate commutation.
    rst = 1'b0;
    cyc(5);
    check("start_gate_off", 32'(bus.gate), 0);
    cyc(5);
    check("start_step_before_edge", 32'(bus.step), 0);
    check("start_hscnt_before_edge", 32'(bus.HSCounter), 0);
    cyc(1);
    check("start_step", 32'(bus.step), 1);
    check("start_gate", 32'(bus.gate), 'h21);
    check("start_hscnt", 32'(bus.HSCounter), 1);
    check("start_hs", 32'(bus.HS), 5);
    cyc(4000 - 11);

    // Steady forward rotation, 4000 cycles per sector.
    for (int i = 0; i < 6; i++) begin
      prev  = bus.step;
      t_chg = -1;
      bus.HS_in = vecs[i].hs;
      for (int c = 1; c <= 4000; c++) begin
        cyc(1);
        if (t_chg < 0 && bus.step != prev) t_chg = c;
      end
      check($sformatf("rot%0d_step", i), 32'(bus.step), 32'(vecs[i].exp_step));
      check($sformatf("rot%0d_latency_%0d", i, t_chg), 32'(t_chg >= 960 && t_chg <= 1060), 1);
      check($sformatf("rot%0d_period", i), 32'(bus.counter_per_cycle), 80);
      check($sformatf("rot%0d_gate_low", i), 32'(bus.gate & vecs[i].low_bit), 32'(vecs[i].low_bit));
      check($sformatf("rot%0d_gate_extra", i), 32'(bus.gate & ~vecs[i].exp_mask), 0);
    end
    check("rot_hscnt", 32'(bus.HSCounter), 7);

    // Reverse and PWM duty.
    bus.dir   = 1'b1;
    bus.HS_in = 3'd1;
    cyc(1100);
    check("rev_step", 32'(bus.step), 5);
    check("rev_bl", 32'(bus.gate & 6'h04), 'h04);
    for (int k = 0; k < 3; k++) begin
      bus.accel = 10'(acc_tab[k]);
      cyc(2);
      ch_cnt = 0; bl_cnt = 0; bad_cnt = 0;
      for (int c = 0; c < 1024; c++) begin
        cyc(1);
        if (bus.gate[1]) ch_cnt++;
        if (bus.gate[2]) bl_cnt++;
        if ((bus.gate & 6'h39) != 6'h00) bad_cnt++;
      end
      check($sformatf("pwm%0d_ch", acc_tab[k]), 32'(ch_cnt), 32'(ch_exp[k]));
      check($sformatf("pwm%0d_bl", acc_tab[k]), 32'(bl_cnt), 1024);
      check($sformatf("pwm%0d_other", acc_tab[k]), 32'(bad_cnt), 0);
    end
    check("rev_hscnt", 32'(bus.HSCounter), 8);

    // Edge during delay: period 80 then an edge only 10 ticks later.
    bus.HS_in = 3'd5;
    cyc(4000);
    check("ed_x_step", 32'(bus.step), 4);
    bus.HS_in = 3'd4;
    cyc(500);
    check("ed_y_pending", 32'(bus.step), 4);
    bus.HS_in = 3'd6;
    cyc(10);
    check("ed_z_before", 32'(bus.step), 4);
    cyc(1);
    check("ed_z_flush", 32'(bus.step), 3);
    check("ed_z_period", 32'(bus.counter_per_cycle), 10);
    check("ed_z_dcnt_clr", 32'(bus.delayAngleCounter), 0);
    cyc(1);
    check("ed_z_hold", 32'(bus.step), 3);
    cyc(150);
    check("ed_z_step", 32'(bus.step), 2);
    check("ed_z_dcnt", 32'(bus.delayAngleCounter), 2);
    check("ed_hscnt", 32'(bus.HSCounter), 11);

    // Glitches shorter than the filter window are ignored.
    foreach (acc_tab[k]) begin
      if (k < 2) begin
        bus.HS_in = 3'd2;
        cyc(k == 0 ? 5 : 7);
        bus.HS_in = 3'd6;
        cyc(20);
        check($sformatf("glitch%0d_hs", k), 32'(bus.HS), 6);
        check($sformatf("glitch%0d_hscnt", k), 32'(bus.HSCounter), 11);
      end
    end

    // Asynchronous reset while a delayed commutation is outstanding.
    cyc(2000);
    bus.HS_in = 3'd2;
    cyc(100);
    check("arst_in_delay_step", 32'(bus.step), 2);
    check("arst_in_delay_cl", 32'(bus.gate & 6'h01), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gate", 32'(bus.gate), 0);
    check("arst_step", 32'(bus.step), 0);
    check("arst_hscnt", 32'(bus.HSCounter), 0);
    check("arst_per", 32'(bus.counter_per_cycle), 0);
    cyc(2);
    rst = 1'b0;

    for (int i = 0; i < 80000 && !stall_done; i++) cyc(1);
    if (!stall_done) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: got not-done expected done");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stall, stall recovery and invalid-code fault on the one-cycle-tick instance.
  initial begin
    rst_s = 1'b1;
    bus_s.enable = 1'b1;
    bus_s.dir    = 1'b0;
    bus_s.HS_in  = 3'd5;
    bus_s.accel  = 10'd1023;
    cyc(3);
    rst_s = 1'b0;
    cyc(11);
    check("s_start_step", 32'(bus_s.step), 1);
    cyc(60000 - 11);
    check("s_no_stall_yet", 32'(bus_s.stall), 0);
    cyc(5600);
    check("s_stall", 32'(bus_s.stall), 1);
    check("s_stall_gate", 32'(bus_s.gate), 0);
    check("s_stall_per", 32'(bus_s.counter_per_cycle), 'hFFFF);
    bus_s.HS_in = 3'd1;
    cyc(10);
    check("s_exit_before", 32'(bus_s.step), 1);
    cyc(1);
    check("s_exit_step", 32'(bus_s.step), 2);
    check("s_exit_stall", 32'(bus_s.stall), 0);
    check("s_exit_cl", 32'(bus_s.gate & 6'h01), 1);
    check("s_exit_hscnt", 32'(bus_s.HSCounter), 2);
    bus_s.HS_in = 3'd7;
    cyc(11);
    check("s_fault", 32'(bus_s.fault), 1);
    check("s_fault_gate", 32'(bus_s.gate), 0);
    check("s_fault_hs", 32'(bus_s.HS), 7);
    check("s_fault_hscnt", 32'(bus_s.HSCounter), 2);
    bus_s.enable = 1'b0;
    cyc(1);
    check("s_fault_clear", 32'(bus_s.fault), 0);
    bus_s.enable = 1'b1;
    cyc(2);
    check("s_restart_fault", 32'(bus_s.fault), 0);
    check("s_restart_gate", 32'(bus_s.gate), 0);
    stall_done = 1'b1;
  end
endmodule

// File: doc/bldc_commutation_scheduler.md
Name: bldc_commutation_scheduler

Overview:
- Sequences six-step commutation of the brushless motor from the three hall sensors.
- Filters hall inputs, measures hall sector period, and delays each commutation by a period-proportional advance angle.
- Gates the high-side switches with an `accel`-driven PWM.
- Sits between hall/throttle inputs and the gate drivers. Exports period, delay and edge counters for on-chip debug probing.

Parameters:
PRESCALE, 50, controlCLK cycles per measurement tick (period/delay timebase)
DELAY_SHIFT, 2, commutation delay = latched period >> DELAY_SHIFT
FILTER_LEN, 8, consecutive stable cycles required to accept a new hall code (1..255)
PWM_BITS, 10, PWM counter and accel width

Ports:
controlCLK  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  run request; low forces IDLE, gates off, clears fault
dir  in  1  0 forward, 1 reverse
HS_in  in  3  raw hall sensors {C,B,A}
accel  in  PWM_BITS  duty demand, 0 = off
gate  out  6  {AH,AL,BH,BL,CH,CL}
HS  out  3  filtered hall code
HSCounter  out  10  valid hall edge count, wraps
counter_per_cycle  out  16  last latched sector period in ticks
delayAngleCounter  out  16  running delay counter
step  out  3  applied drive step 0..5
stall  out  1  period saturated, motor stopped
fault  out  1  sticky invalid hall code

Behaviour:
- Reset: every output and internal register is 0. State is IDLE.
- Hall path: 2-FF synchroniser on HS_in. A new synced code is accepted into HS only after FILTER_LEN consecutive identical cycles.
  - Acceptance produces a 1-cycle edge pulse.
  - Total latency from input change to edge pulse = 2 + FILTER_LEN cycles.
- Hall step map: 5→0, 1→1, 3→2, 2→3, 6→4, 4→5. Codes 0 and 7 are invalid.
  - An accepted invalid code sets fault (sticky until enable=0 or rst) and forces state IDLE.
- Tick: a prescaler produces a 1-cycle tick every PRESCALE controlCLK cycles. The prescaler free-runs from reset.
- Period counter: increments on each tick, saturating at 0xFFFF. Cleared on each valid edge.
  - On each valid edge, the counter value (before clear) is latched into counter_per_cycle.
- Drive step: target = (hall_step+1) mod 6 when dir=0; (hall_step+4) mod 6 when dir=1.
- Drive table, by step 0..5: AH+BL, AH+CL, BH+CL, BH+AL, CH+AL, CH+BL. Unlisted gates are 0.
- PWM: a PWM_BITS free-running counter. pwm = (cnt < accel).
  - Driven high-side gate = table & pwm. Low side is static on.
  - accel=0 means no high-side pulses. Maximum accel gives 1 low cycle per wrap.
- State machine:
  - IDLE: gates=0. On enable=1 and fault=0 → START.
  - START: gates=0, waiting for the first valid edge. On edge: apply target step immediately (step updates on the cycle after the edge pulse) → RUN. No delay is applied because the period is unknown.
  - RUN: on a valid edge, latch period; delay_target = latched period >> DELAY_SHIFT; clear delayAngleCounter; hold pending step → DELAY.
  - DELAY: delayAngleCounter increments each tick. When delayAngleCounter >= delay_target, apply pending step → RUN.
    - delay_target=0: apply on the cycle after the edge.
    - A new edge while in DELAY: apply the old pending step that cycle, then relatch and restart DELAY with the new target.
  - STALL: entered from RUN or DELAY when the period counter reaches 0xFFFF. Sets stall=1, gates=0, counter_per_cycle=0xFFFF. On a valid edge: stall=0, apply step immediately → RUN.
  - Any state: enable=0 → IDLE next cycle; gates=0, fault cleared, counters kept. A valid edge → START-style immediate commutation.
- HSCounter: increments on every valid edge in all states except IDLE. Wraps 1023→0.
- Direction change while running: takes effect at the next valid edge.
- rst asserted mid-operation: all outputs 0 immediately (asynchronous).

Test Plan:
1. Reset and startup: assert rst, then release; enable=1, accel=1023, HS_in=5 → gate=0 while in START. After 2+8 cycles, step=1 and gate has AH, CL active. HSCounter=1.
2. Steady rotation: hall sequence 5,1,3,2,6,4 forward, 4000 controlCLK (80 ticks) per sector → counter_per_cycle=80; step changes 20 ticks (1000±50 cycles) after each edge pulse; step sequence 2,3,4,5,0,1.
3. Reverse and PWM: dir=1, hall=1 → step=5 (CH+BL). accel=256 → CH high 256 of every 1024 cycles, BL constant.
4. Edge during delay: period=80, next edge after 10 ticks → previous pending step applied that cycle; new delay_target=2 (10>>2).
5. Stall and invalid code: hold hall 65535 ticks → stall=1, gates=0, counter_per_cycle=0xFFFF; next valid edge clears stall with immediate step. Apply code 7 → fault=1, gates=0; enable pulse low clears fault.
6. Glitch filter: 5-cycle hall glitch → no edge, HSCounter unchanged. Async rst mid-DELAY → gates=0 in the same cycle.
